// File: rtl/flash_read_arbiter.sv
// Two-port round-robin arbiter for the cartridge SPI flash: runs a mode-0 READ burst and streams bytes back.
// Define FLASH_FAST_READ_EN to issue FAST READ (0x0B) with an 8-clock dummy phase after the address.
module flash_read_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [23:0] r0_addr,
  input  logic [15:0] r0_len,
  input  logic        r1_req,
  input  logic [23:0] r1_addr,
  input  logic [15:0] r1_len,
  output logic [1:0]  gnt,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [1:0]  done,
  output logic        busy,
  output logic        sck,
  output logic        mosi,
  output logic        cs_n,
  input  logic        miso
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE, GAP, CMD, ADDR, DATA, HOLD, FINISH
`ifdef FLASH_FAST_READ_EN
    , DUMMY
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        busy_q, busy_d;
  logic [1:0]  done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        last_q, last_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  gap_q, gap_d;

  logic [1:0]  req_eff;
  logic        pick;
  logic        half_end;
  logic        shift_phase;
  logic        rise;
  logic        fall;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    done_d     = 2'b00;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    last_d     = last_q;
    addr_d     = addr_q;
    len_d      = len_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    div_d      = div_q;
    bit_d      = bit_q;
    pick       = 1'b0;

    // A port whose done is pulsing this cycle may still hold req; it must not be re-granted.
    req_eff  = {r1_req, r0_req} & ~done_q;
    half_end = (div_q == DIV_LAST);

    // Counts cycles since cs_n last rose; saturates so it keeps running through IDLE.
    if (!cs_n_q)
      gap_d = 8'd0;
    else if (gap_q != 8'hFF)
      gap_d = gap_q + 8'd1;
    else
      gap_d = gap_q;

    shift_phase = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA)
`ifdef FLASH_FAST_READ_EN
                  || (state_q == DUMMY)
`endif
                  ;
    rise = shift_phase && !sck_q && half_end;
    fall = shift_phase &&  sck_q && half_end;

    if (shift_phase) begin
      div_d = half_end ? 8'd0 : div_q + 8'd1;
      if (half_end)
        sck_d = ~sck_q;
    end
    if (fall) begin
      tx_d   = {tx_q[30:0], 1'b0};
      mosi_d = tx_q[30];
      bit_d  = bit_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (req_eff != 2'b00) begin
          pick   = (req_eff == 2'b11) ? ~last_q : req_eff[1];
          gnt_d  = pick ? 2'b10 : 2'b01;
          addr_d = pick ? r1_addr : r0_addr;
          len_d  = pick ? r1_len : r0_len;
          busy_d = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (len_q == 16'd0) begin
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
          last_d  = gnt_q[1];
          state_d = IDLE;
        end else if (gap_q >= GAP_LAST) begin
          cs_n_d  = 1'b0;
          tx_d    = {CMD_BYTE, addr_q};
          mosi_d  = CMD_BYTE[7];
          sck_d   = 1'b0;
          div_d   = 8'd0;
          bit_d   = 5'd0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (fall && bit_q == 5'd7) begin
          bit_d   = 5'd0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (fall && bit_q == 5'd23) begin
          bit_d   = 5'd0;
          mosi_d  = 1'b0;
`ifdef FLASH_FAST_READ_EN
          state_d = DUMMY;
`else
          state_d = DATA;
`endif
        end
      end
`ifdef FLASH_FAST_READ_EN
      DUMMY: begin
        if (fall && bit_q == 5'd7) begin
          bit_d   = 5'd0;
          state_d = DATA;
        end
      end
`endif
      DATA: begin
        if (rise)
          rx_d = {rx_q[6:0], miso};
        if (fall && bit_q == 5'd7) begin
          bit_d      = 5'd0;
          rd_data_d  = rx_q;
          rd_valid_d = 1'b1;
          len_d      = len_q - 16'd1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (len_q != 16'd0) begin
            div_d   = 8'd0;
            state_d = DATA;
          end else begin
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        done_d  = gnt_q;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        last_d  = gnt_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      last_q     <= 1'b1;
      addr_q     <= 24'd0;
      len_q      <= 16'd0;
      tx_q       <= 32'd0;
      rx_q       <= 8'd0;
      div_q      <= 8'd0;
      bit_q      <= 5'd0;
      gap_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single cartridge SPI serial flash between two requesters: port 0, the NEC-IR boot loader / CHR-RAM preload, and port 1, the AVR serial debug dump.
- Each requester posts a burst read (24-bit address, 16-bit byte count).
- The block arbitrates between them, runs the flash READ transaction in SPI mode 0 and streams bytes back with a valid/ready handshake.
- It sits between the requesters and the flash_cs_n, sck, mosi and miso pins, upstream of the PPU data-bus mux.

Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period; legal values are 1 to 255.
- CS_IDLE, 4: minimum clk cycles that cs_n stays high between transactions; legal values are 1 to 255.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 request; held high until the matching done pulse
- r0_addr  in  24  port 0 start byte address
- r0_len  in  16  port 0 byte count
- r1_req  in  1  port 1 request; same rules as port 0
- r1_addr  in  24  port 1 start byte address
- r1_len  in  16  port 1 byte count
- gnt  out  2  one-hot grant, held for the whole transaction
- rd_data  out  8  read byte
- rd_valid  out  1  rd_data is valid
- rd_ready  in  1  current owner accepts the byte
- done  out  2  one-cycle pulse per port when its burst is complete
- busy  out  1  a transaction is in progress
- sck  out  1  flash clock
- mosi  out  1  flash data in
- cs_n  out  1  flash chip select, active low
- miso  in  1  flash data out

Behaviour:
- Reset values:
  - gnt=0, rd_valid=0, rd_data=0, done=0, busy=0.
  - sck=0, mosi=0, cs_n=1.
  - State IDLE; last-grant pointer = 1, so port 0 wins the first tie.
- States: IDLE, GAP, CMD, ADDR, DATA, HOLD, FINISH.
- IDLE:
  - If any req is high, grant round-robin: the port not granted last wins a tie; a lone requester wins immediately.
  - Latch addr/len, set gnt and busy, then go to GAP.
  - Latency from req to gnt is 1 cycle.
- GAP:
  - cs_n=1 for CS_IDLE cycles, measured from the previous cs_n rising edge; the counter keeps running through IDLE.
  - If the latched len==0: pulse done for the owner, clear gnt, return to IDLE. cs_n is never asserted.
  - Otherwise drop cs_n and go to CMD.
- SPI timing (mode 0):
  - A bit takes 2*CLK_DIV clk cycles.
  - mosi is set while sck is low; sck rises after CLK_DIV cycles; miso is sampled on the clk edge where sck rises; sck falls CLK_DIV cycles later.
  - Data is MSB first.
- CMD: shift out 0x03, 8 bits.
- ADDR: shift out the latched address, 24 bits, MSB first.
- DATA:
  - Shift in 8 bits, then load rd_data, assert rd_valid, decrement the remaining count and go to HOLD.
  - sck stays low while waiting in HOLD.
- HOLD:
  - rd_valid stays high and rd_data stays stable until rd_valid and rd_ready are both high.
  - On that transfer: if remaining != 0, go back to DATA (the next sck rise follows after CLK_DIV cycles); otherwise go to FINISH.
  - A rd_ready that is already high does not shorten the first cycle: rd_valid is high for at least 1 cycle.
- FINISH: cs_n=1, sck=0, pulse done for the owner for 1 cycle, clear gnt and busy, update the last-grant pointer, go to IDLE.
- Request handling:
  - A requester dropping req mid-burst is ignored; the burst completes.
  - A request arriving during a burst waits.
  - After a done pulse the other port, if requesting, wins next, so no port starves.
- Address arithmetic: the address is sent once and the flash auto-increments internally; the block does no address wrap handling.
- len=65535 is a legal maximum.
- Reset mid-transaction: all outputs return immediately (asynchronously) to their reset values and cs_n=1. The partial burst is lost, with no done pulse.

Optional Feature:
- Macro: FLASH_FAST_READ_EN.
- Defined:
  - Command byte is 0x0B.
  - A DUMMY state (8 sck cycles, mosi=0) is inserted between ADDR and DATA.
  - Intended for CLK_DIV=1 (25 MHz SCK).
- Undefined: command byte is 0x03 with no dummy phase, and the DUMMY state does not exist.

Test Plan:
- Single read, CLK_DIV=2:
  - Stimulus: r0_req with addr=0x012345, len=2; flash model returns 0xA5, 0x3C; rd_ready held high.
  - Required: mosi carries 0x03,0x01,0x23,0x45; rd_data gives 0xA5 then 0x3C; done[0] pulses once; cs_n is low for 32*4 + 16*4 cycles plus handshake.
- Backpressure:
  - Stimulus: len=3; rd_ready low for 20 cycles after the first rd_valid.
  - Required: rd_data stays stable, sck is held low with no edges, 3 bytes arrive in order, and no byte is dropped or duplicated.
- Simultaneous requests:
  - Stimulus: r0 and r1 raised in the same cycle, both len=1, both held.
  - Required: gnt=01 first; after done[0], gnt=10; cs_n is high at least CS_IDLE cycles between the two bursts.
- Zero length:
  - Stimulus: r1_len=0.
  - Required: done[1] pulses; cs_n stays 1; no sck edges.
- Reset mid-ADDR:
  - Stimulus: rst asserted during the ADDR phase.
  - Required: cs_n=1, sck=0, gnt=0, busy=0 with no clock edge needed; no done pulse; the next request runs cleanly.
- FLASH_FAST_READ_EN defined:
  - Stimulus: read at addr=0x000010, len=1.
  - Required: mosi carries 0x0B,0x00,0x00,0x10, then 8 dummy clocks, then the byte is captured.
